rsa_sub16_pipe: RTL and testbench

//  Pipelined ripple-borrow subtractor, the subtract-direction counterpart of the 16-bit

---
 rtl/rsa_sub16_pipe.sv | 164 ++++++++++++++++
 tb/tb_rsa_sub16_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rsa_sub16_pipe.sv
// ---------------------------------------------------------------------------
// rsa_sub16_pipe
// Pipelined ripple-borrow subtractor: diff = a - b - bin (mod 2^WIDTH), with
// borrow-out (bout) and two's-complement overflow (ovf). Each stage resolves
// one SLICE-bit borrow slice. All stages move together under a single global
// advance enable, so a stalled output holds every stage, including bubbles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational from adv)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow-in
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   diff       a - b - bin truncated to WIDTH (registered)
//   bout       borrow out of the MSB (registered)
//   ovf        signed overflow (registered)
//
// Structure: stages 0..STAGES-2 are intermediate registers, the last stage
// is the output register itself, so a beat accepted at edge N is visible
// after edge N+STAGES-1. Stage 0 resolves slice 0 directly from the input
// operands. Requires STAGES >= 2.
// ---------------------------------------------------------------------------
module rsa_sub16_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;

  // Ripple-borrow over one slice; returns {borrow_out, diff_slice}.
  function automatic logic [SLICE:0] sub_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             br_in
  );
    logic [SLICE-1:0] d;
    logic             br;
    br = br_in;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~x[i] & br) | (y[i] & br);
    end
    return {br, d};
  endfunction

  logic             out_valid_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             adv;

  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign diff      = diff_reg;
  assign bout      = bout_reg;
  assign ovf       = ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES - 1; gi++) begin : g_stage
      localparam int LO   = gi * SLICE;
      localparam int HI_W = WIDTH - (gi + 1) * SLICE;

      // word_reg: resolved diff bits below the boundary, raw a bits above it,
      // so a[MSB] survives untouched until the final stage needs it for ovf.
      logic                  valid_reg;
      logic [WIDTH-1:0]      word_reg;
      logic [HI_W-1:0]       b_hi_reg;
      logic                  br_reg;

      logic                  src_valid;
      logic [WIDTH-1:0]      src_word;
      logic [HI_W+SLICE-1:0] src_b;
      logic                  src_br;
      logic [SLICE:0]        res;
      logic [WIDTH-1:0]      word_next;

      if (gi == 0) begin : g_src
        assign src_valid = in_valid;
        assign src_word  = a;
        assign src_b     = b;
        assign src_br    = bin;
      end else begin : g_src
        assign src_valid = g_stage[gi-1].valid_reg;
        assign src_word  = g_stage[gi-1].word_reg;
        assign src_b     = g_stage[gi-1].b_hi_reg;
        assign src_br    = g_stage[gi-1].br_reg;
      end

      assign res = sub_slice(src_word[LO +: SLICE], src_b[SLICE-1:0], src_br);

      always_comb begin
        word_next               = src_word;
        word_next[LO +: SLICE]  = res[SLICE-1:0];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          word_reg  <= '0;
          b_hi_reg  <= '0;
          br_reg    <= 1'b0;
        end else if (adv) begin
          valid_reg <= src_valid;
          word_reg  <= word_next;
          b_hi_reg  <= src_b[HI_W+SLICE-1:SLICE];
          br_reg    <= res[SLICE];
        end
      end
    end
  endgenerate

  // Final stage: top slice resolved straight into the output registers.
  logic [WIDTH-1:0] last_word;
  logic [SLICE-1:0] last_b;
  logic             last_br;
  logic             last_valid;
  logic [SLICE:0]   last_res;
  logic             ovf_next;

  assign last_word  = g_stage[STAGES-2].word_reg;
  assign last_b     = g_stage[STAGES-2].b_hi_reg;
  assign last_br    = g_stage[STAGES-2].br_reg;
  assign last_valid = g_stage[STAGES-2].valid_reg;
  assign last_res   = sub_slice(last_word[WIDTH-1 -: SLICE], last_b, last_br);
  assign ovf_next   = (last_word[WIDTH-1] != last_b[SLICE-1]) &&
                      (last_res[SLICE-1] != last_word[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      bout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= last_valid;
      // Result fields only change when a real beat lands; bubbles keep the
      // previous result on the outputs.
      if (last_valid) begin
        diff_reg <= {last_res[SLICE-1:0], last_word[WIDTH-SLICE-1:0]};
        bout_reg <= last_res[SLICE];
        ovf_reg  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_rsa_sub16_pipe.sv
// ---------------------------------------------------------------------------
// tb_rsa_sub16_pipe
// Directed bench for rsa_sub16_pipe: reset state, single beats with known
// results and latency, a back-to-back stream with a downstream stall, and a
// reset that drops in-flight beats.
// ---------------------------------------------------------------------------
module tb_rsa_sub16_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_sub16_pipe #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat with out_ready held high; checks 3-edge latency and result.
  task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vbin, input logic [15:0] ed, input logic eb,
                         input logic eo);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_diff"},  {16'd0, diff},      {16'd0, ed});
    chk({tag, "_bout"},  {31'd0, bout},      {31'd0, eb});
    chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eo});
    $display("beat %s a=%h b=%h bin=%0d diff=%h bout=%0d ovf=%0d", tag, va, vb, vbin,
             diff, bout, ovf);
  endtask

  logic [15:0] sa [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                          16'h0100, 16'hFFFF, 16'h0003, 16'h5000};
  logic [15:0] sb [8] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                          16'h0001, 16'h0001, 16'h0007, 16'h0001};
  logic [15:0] sd [8] = '{16'h1100, 16'h2200, 16'h3300, 16'h4400,
                          16'h00FF, 16'hFFFE, 16'hFFFC, 16'h4FFF};
  logic        sbo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int tx;
    int rx;
    int seen;
    logic acc;
    logic ret;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff",      {16'd0, diff},      32'd0);
    chk("rst_bout",      {31'd0, bout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Directed single beats
    run_one("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_one("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_one("bin_wrap",16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_one("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_one("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_one("ripple",  16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    run_one("bin_one", 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Back-to-back stream with a 3-cycle downstream stall
    @(posedge clk);
    tx = 0; rx = 0;
    for (int t = 0; t < 40 && rx < 8; t++) begin
      @(posedge clk); #1;
      if (tx < 8) begin
        in_valid = 1'b1; a = sa[tx]; b = sb[tx]; bin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(t >= 5 && t <= 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (t >= 5 && t <= 7) begin
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
        chk("stall_diff_hold", {16'd0, diff},      {16'd0, sd[rx]});
      end
      if (ret) begin
        chk("stream_diff", {16'd0, diff}, {16'd0, sd[rx]});
        chk("stream_bout", {31'd0, bout}, {31'd0, sbo[rx]});
        $display("stream rx=%0d diff=%h bout=%0d", rx, diff, bout);
        rx++;
      end
      if (acc) tx++;
    end
    chk("stream_count", rx, 8);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stream_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream drops in-flight beats
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 16'h0F00 + 16'(k); b = 16'h0001; bin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_diff",     {16'd0, diff},     32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_dropped", seen, 0);
    $display("midrst out_valid_seen=%0d", seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
